muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_sequencer.sv | 117 +++++++++++
 tb/tb_muldiv_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit, one bit per cycle, stalls the pipeline until done.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);
  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  state_t            state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, m_q, m_d, result_q, result_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              sa_en, sb_en, sign_a, sign_b, rem_op, div_zero, ovf, ge;
  logic [XLEN-1:0]   abs_a, abs_b, special, dv, fix_res;
  logic [XLEN:0]     sum, trial;
  logic [2*XLEN-1:0] mul_next, div_next, prod;
  // Signedness per funct3: MULH both, MULHSU rs1 only, DIV/REM both.
  assign sa_en    = f3_q[2] ? ~f3_q[0] : (f3_q[1:0] == 2'b01 || f3_q[1:0] == 2'b10);
  assign sb_en    = f3_q[2] ? ~f3_q[0] : (f3_q[1:0] == 2'b01);
  assign sign_a   = sa_en & a_q[XLEN-1];
  assign sign_b   = sb_en & b_q[XLEN-1];
  assign abs_a    = sign_a ? -a_q : a_q;
  assign abs_b    = sign_b ? -b_q : b_q;
  assign rem_op   = f3_q[2] & f3_q[1];
  assign div_zero = (b_q == '0);
  assign ovf      = f3_q[2] & ~f3_q[0] & (a_q == MIN) & (b_q == '1);
  assign special  = div_zero ? (rem_op ? a_q : '1) : (rem_op ? '0 : a_q);
  assign sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign mul_next = {sum, acc_q[XLEN-1:1]};
  // Remainder is always below the divisor, so the shifted value fits in XLEN+1 bits.
  assign trial    = acc_q[2*XLEN-1:XLEN-1] - {1'b0, m_q};
  assign ge       = ~trial[XLEN];
  assign div_next = {ge ? trial[XLEN-1:0] : acc_q[2*XLEN-2:XLEN-1], acc_q[XLEN-2:0], ge};
  assign prod     = neg_q ? -acc_q : acc_q;
  assign dv       = rem_op ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
  assign fix_res  = f3_q[2] ? (neg_q ? -dv : dv)
                  : (f3_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = PREP;
        f3_d    = funct3;
        a_d     = srcA;
        b_d     = srcB;
      end
      PREP: begin
        neg_d   = rem_op ? sign_a : sign_a ^ sign_b;
        cnt_d   = CW'(XLEN);
        m_d     = f3_q[2] ? abs_b : abs_a;
        acc_d   = {{XLEN{1'b0}}, f3_q[2] ? abs_a : abs_b};
        state_d = RUN;
        if (f3_q[2] && (div_zero || ovf)) begin
          result_d = special;
          state_d  = DONE;
        end
      end
      RUN: begin
        acc_d = f3_q[2] ? div_next : mul_next;
        cnt_d = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? FIX : RUN;
      end
      FIX: begin
        result_d = fix_res;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end
  assign busy   = (state_q != IDLE);
  assign stall  = (state_q == IDLE && start) || state_q == PREP || state_q == RUN || state_q == FIX;
  assign done   = (state_q == DONE);
  assign result = result_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vector table plus hand-written corner sequences for muldiv_sequencer.
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, busy, stall, done;
  logic [2:0]  funct3;
  logic [31:0] srcA, srcB, result;
  int          n_chk = 0, n_fail = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b, exp;
    int          lat;
  } vec_t;
  vec_t v[20];

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .srcA(srcA), .srcB(srcB),
    .busy(busy), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    funct3 = f;
    srcA = a;
    srcB = b;
    start = 1'b1;
    #1 chk("accept stall", {31'b0, stall}, 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    srcA = $urandom;
    srcB = $urandom;
    funct3 = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(input string nm, input int exp_lat, input logic [31:0] exp_res, input int poke_k);
    int done_k = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == poke_k) begin
        start = 1'b1;
        srcA = $urandom;
        srcB = $urandom;
      end
      if (k == poke_k + 1) start = 1'b0;
      if (done) begin
        done_k = k;
        break;
      end
      chk({nm, " stall"}, {31'b0, stall}, 32'd1);
    end
    chk({nm, " latency"}, 32'(done_k), 32'(exp_lat));
    chk({nm, " result"}, result, exp_res);
    chk({nm, " stall@done"}, {31'b0, stall}, 32'd0);
    chk({nm, " busy@done"}, {31'b0, busy}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    v[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 35};
    v[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 35};
    v[2]  = '{3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 35};
    v[3]  = '{3'b010, 32'h80000000, 32'h80000000, 32'hC0000000, 35};
    v[4]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35};
    v[5]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 35};
    v[6]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 35};
    v[7]  = '{3'b101, 32'd100,      32'd7,        32'd14,       35};
    v[8]  = '{3'b111, 32'd100,      32'd7,        32'd2,        35};
    v[9]  = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 2};
    v[10] = '{3'b110, 32'd5,        32'd0,        32'd5,        2};
    v[11] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2};
    v[12] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2};
    v[13] = '{3'b000, 32'h12345678, 32'h10,       32'h23456780, 35};
    v[14] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        35};
    v[15] = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 35};
    v[16] = '{3'b100, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        35};
    v[17] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        35};
    v[18] = '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 2};
    v[19] = '{3'b111, 32'd9,        32'd0,        32'd9,        2};

    rst = 1'b1;
    start = 1'b0;
    funct3 = 3'b0;
    srcA = '0;
    srcB = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset stall", {31'b0, stall}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      issue(v[i].f3, v[i].a, v[i].b);
      wait_done($sformatf("vec%0d", i), v[i].lat, v[i].exp, 0);
      @(negedge clk);
      chk($sformatf("vec%0d done cleared", i), {31'b0, done}, 32'd0);
      chk($sformatf("vec%0d idle", i), {31'b0, busy}, 32'd0);
    end

    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("b2b first", 35, 32'hFFFFFFFE, 10);
    funct3 = 3'b101;
    srcA = 32'd100;
    srcB = 32'd7;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b2b idle done", {31'b0, done}, 32'd0);
    chk("b2b idle busy", {31'b0, busy}, 32'd0);
    chk("b2b idle stall", {31'b0, stall}, 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    srcA = $urandom;
    srcB = $urandom;
    wait_done("b2b second", 35, 32'd14, 0);
    @(negedge clk);

    issue(3'b000, 32'd7, 32'hFFFFFFFD);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort stall", {31'b0, stall}, 32'd0);
    chk("abort done", {31'b0, done}, 32'd0);
    chk("abort result", result, 32'd0);
    begin
      int seen = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (done) seen++;
      end
      chk("abort no done", 32'(seen), 32'd0);
    end
    issue(3'b101, 32'd9, 32'd3);
    wait_done("after abort", 35, 32'd3, 0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
